// File: rtl/johnson_pkg.sv
// Shared types and code tables for the Johnson phase monitor.
// Both tables list the eight legal codes in sequence order, index 0 = 4'b0000.
package johnson_pkg;

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_TRACK   = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_FAULT   = 2'd3
   } jpm_state_e;

   // Packed tables: element [i] holds the code at sequence index i.
   localparam logic [7:0][3:0] JC_TABLE_R = {4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                             4'b1110, 4'b1100, 4'b1000, 4'b0000};
   localparam logic [7:0][3:0] JC_TABLE_L = {4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                             4'b0111, 4'b0011, 4'b0001, 4'b0000};

   // Returns {legal, idx}; idx is 0 when the code is not in the table.
   function automatic logic [3:0] jc_index(input logic [3:0] code, input logic dir);
      logic [3:0] res;
      logic [3:0] entry;
      res = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         entry = (dir == 1'b0) ? JC_TABLE_R[i] : JC_TABLE_L[i];
         if (code == entry) begin
            res = {1'b1, 3'(i)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legality, binary index and one-hot phase
// for the sequence direction selected by DIR.
module johnson_decode
   import johnson_pkg::*;
#(
   parameter bit DIR = 1'b0
) (
   input  logic [3:0] code,
   output logic       legal,
   output logic [2:0] idx,
   output logic [7:0] onehot
);

   logic [3:0] lookup_s;

   // Table lookup and one-hot expansion; illegal codes give an all-zero phase
   always_comb begin
      lookup_s = jc_index(code, DIR);
      legal    = lookup_s[3];
      idx      = lookup_s[2:0];
      if (lookup_s[3]) begin
         onehot = 8'b0000_0001 << lookup_s[2:0];
      end else begin
         onehot = 8'b0000_0000;
      end
   end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Validates a sampled Johnson counter code stream step by step and publishes a
// registered phase, lock status, sticky error and revolution count.
module johnson_phase_monitor
   import johnson_pkg::*;
#(
   parameter bit          DIR      = 1'b0,
   parameter int unsigned LOCK_CNT = 8,
   parameter int unsigned REV_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       q,
   input  logic             err_clr,
   output logic [7:0]       phase,
   output logic [2:0]       phase_idx,
   output logic             valid,
   output logic             locked,
   output logic             err,
   output logic [REV_W-1:0] rev_count
);

   localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_CNT);

   jpm_state_e       state_r, state_nx_s;
   logic [7:0]       run_r, run_nx_s, run_inc_s;
   logic [2:0]       prev_r, prev_nx_s;
   logic [REV_W-1:0] rev_r, rev_nx_s;
   logic             err_r, err_nx_s;
   logic             locked_r;
   logic [7:0]       phase_r;
   logic [2:0]       phase_idx_r;
   logic             valid_r;

   logic             legal_s;
   logic [2:0]       idx_s;
   logic [7:0]       onehot_s;
   logic             step_s, hold_s, wrap_s, viol_s;

   johnson_decode #(.DIR(DIR)) u_decode (
      .code   (q),
      .legal  (legal_s),
      .idx    (idx_s),
      .onehot (onehot_s)
   );

   // Step classification against the previously accepted index
   always_comb begin
      step_s    = legal_s && (idx_s == 3'(prev_r + 3'd1));
      hold_s    = legal_s && (idx_s == prev_r);
      wrap_s    = (prev_r == 3'd7) && (idx_s == 3'd0);
      if (run_r < LOCK_CNT_C) begin
         run_inc_s = run_r + 8'd1;
      end else begin
         run_inc_s = run_r;
      end
   end

   // Next-state, run/revolution counters and sticky error
   always_comb begin
      state_nx_s = state_r;
      run_nx_s   = run_r;
      prev_nx_s  = prev_r;
      rev_nx_s   = rev_r;
      viol_s     = 1'b0;
      if (en) begin
         case (state_r)
            ST_ACQUIRE, ST_FAULT: begin
               if (legal_s) begin
                  state_nx_s = ST_TRACK;
                  run_nx_s   = 8'd0;
                  prev_nx_s  = idx_s;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_TRACK: begin
               if (step_s) begin
                  run_nx_s  = run_inc_s;
                  prev_nx_s = idx_s;
                  if (run_inc_s == LOCK_CNT_C) begin
                     state_nx_s = ST_LOCKED;
                  end else begin
                     state_nx_s = ST_TRACK;
                  end
               end else if (hold_s) begin
                  state_nx_s = ST_TRACK;
               end else begin
                  state_nx_s = ST_FAULT;
                  viol_s     = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (step_s) begin
                  prev_nx_s = idx_s;
                  if (wrap_s) begin
                     rev_nx_s = rev_r + REV_W'(1);
                  end else begin
                     rev_nx_s = rev_r;
                  end
               end else if (hold_s) begin
                  state_nx_s = ST_LOCKED;
               end else begin
                  state_nx_s = ST_FAULT;
                  viol_s     = 1'b1;
               end
            end
            default: begin
               state_nx_s = ST_ACQUIRE;
               run_nx_s   = 8'd0;
               prev_nx_s  = 3'd0;
            end
         endcase
      end else begin
         state_nx_s = state_r;
      end

      // A new violation wins over a simultaneous clear
      if (viol_s) begin
         err_nx_s = 1'b1;
      end else if (err_clr) begin
         err_nx_s = 1'b0;
      end else begin
         err_nx_s = err_r;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_ACQUIRE;
         run_r       <= 8'd0;
         prev_r      <= 3'd0;
         rev_r       <= '0;
         err_r       <= 1'b0;
         locked_r    <= 1'b0;
         phase_r     <= 8'h00;
         phase_idx_r <= 3'd0;
         valid_r     <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         run_r    <= run_nx_s;
         prev_r   <= prev_nx_s;
         rev_r    <= rev_nx_s;
         err_r    <= err_nx_s;
         locked_r <= (state_nx_s == ST_LOCKED);
         if (en) begin
            phase_r <= legal_s ? onehot_s : 8'h00;
            valid_r <= legal_s;
            if (legal_s) begin
               phase_idx_r <= idx_s;
            end
         end
      end
   end

   assign phase     = phase_r;
   assign phase_idx = phase_idx_r;
   assign valid     = valid_r;
   assign locked    = locked_r;
   assign err       = err_r;
   assign rev_count = rev_r;

endmodule
